// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC into instruction memory, queues fetched words in order and
// hands them to issue. Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  input  logic        isend_in,
  output logic        issue_valid,
  output logic [31:0] issue_instr,
  output logic [31:0] issue_pc,
  input  logic        issue_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     pc_reg, pc_next;
  logic [AW-1:0]   head_reg, head_next;
  logic [AW-1:0]   tail_reg, tail_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem [DEPTH];
  logic [DEPTH-1:0] wr_sel;

  logic flush, deq, deq_eff, full, enq;

  // A redirect outranks everything except the halted state, which only reset can leave.
  assign flush   = redirect_valid && (state_reg != ST_HALTED);
  assign deq     = issue_valid && issue_ready;
  assign deq_eff = deq && !flush;
  assign full    = (count_reg == CW'(DEPTH));
  assign enq     = (state_reg == ST_RUN) && !isend_in && !flush && (!full || deq);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = enq && (tail_reg == AW'(gi));
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
      pc_next    = redirect_pc;
      state_next = ST_RUN;
    end else begin
      if (enq) begin
        tail_next = tail_reg + 1'b1;
        pc_next   = pc_reg + 32'd1;
      end
      if (deq_eff) begin
        head_next = head_reg + 1'b1;
      end
      count_next = count_reg + CW'(enq) - CW'(deq_eff);
      case (state_reg)
        ST_RUN:    if (isend_in) state_next = ST_DRAIN;
        ST_DRAIN:  if (count_next == '0) state_next = ST_HALTED;
        ST_HALTED: state_next = ST_HALTED;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      pc_reg    <= PC_RESET;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entries are cleared on reset so the head reads as zero before the first fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          instr_mem[i] <= instr_in;
          pc_mem[i]    <= pc_reg;
        end
      end
    end
  end

  assign pc_out      = pc_reg;
  assign issue_valid = (count_reg != '0);
  assign issue_instr = instr_mem[head_reg];
  assign issue_pc    = pc_mem[head_reg];
  assign halted      = (state_reg == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_reg, perf_stall_reg;
  logic        stall;

  assign stall = (state_reg == ST_RUN) && !isend_in && !redirect_valid && full && !deq;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
    end else begin
      if (enq)   perf_fetched_reg <= perf_fetched_reg + 32'd1;
      if (stall) perf_stall_reg   <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the PC into the combinational instruction memory and captures each fetched word into a small in-order instruction queue.
- Presents the queue head to the Tomasulo issue stage through a valid/ready handshake.
- Stops fetching at the end-of-program opcode (instr[31:26] = 6'b111111), drains the queue, then reports halt.
- Accepts branch/jump redirects that flush the queue and restart fetch at a new word address.

Parameters:
- DEPTH, 4, instruction queue entries; power of two, minimum 2.
- PC_RESET, 32'd0, word address loaded into PC on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_out  output  32  word address to instruction memory; registered.
- instr_in  input  32  instruction word returned combinationally for pc_out.
- isend_in  input  1  end-of-program flag from memory for pc_out, same cycle as instr_in.
- issue_valid  output  1  queue head is valid.
- issue_instr  output  32  queue head instruction.
- issue_pc  output  32  word address of the queue head.
- issue_ready  input  1  issue stage accepts the head this cycle.
- redirect_valid  input  1  flush the queue and load redirect_pc.
- redirect_pc  input  32  new fetch word address.
- halted  output  1  program end reached and queue drained.

Behaviour:
- Reset (rst high at a clock edge): pc_out=PC_RESET; queue empty (head, tail and count all 0); state=RUN; issue_valid=0; issue_instr=0; issue_pc=0; halted=0. Reset mid-operation discards all queued entries and any pending halt.
- States and transitions:
  - RUN: fetch active.
  - DRAIN: end seen; no fetch; queue still issuing.
  - HALTED: idle; halted=1.
  - RUN->DRAIN when isend_in=1 and no redirect.
  - DRAIN->HALTED at the first edge where count is 0 after any dequeue.
  - RUN/DRAIN->RUN on redirect.
  - HALTED is left only by rst; redirect_valid is ignored in HALTED.
- deq = issue_valid & issue_ready. issue_valid=(count!=0); issue_instr and issue_pc are the head entry. All outputs are functions of registers only; there are no combinational input-to-output paths.
- Enqueue in RUN when isend_in=0 and (count<DEPTH or deq):
  - Write {pc_out, instr_in} at tail.
  - Next pc_out = pc_out+1, modulo 2^32 (0xFFFFFFFF wraps to 0).
- Otherwise pc_out holds; a full queue stalls fetch, with no lost or duplicated words.
- Full with simultaneous deq: enqueue and dequeue both occur; count is unchanged.
- Empty: deq is impossible; issue_instr and issue_pc hold their last values and are don't-care.
- End opcode: the word with isend_in=1 is never enqueued. pc_out holds the end address in DRAIN and HALTED.
- Redirect (highest priority, RUN or DRAIN):
  - Queue flushed to count=0; any same-cycle enqueue and deq are suppressed.
  - pc_out=redirect_pc; state=RUN.
  - Next cycle issue_valid=0; fetch resumes at redirect_pc.
  - Redirect beats isend_in in the same cycle.
- Pointer wrap: head and tail wrap modulo DEPTH; count ranges 0..DEPTH.
- Latency:
  - A fetched word is visible on issue_valid the edge after its fetch cycle.
  - Minimum redirect-to-issue latency is 2 cycles.
  - Sustained throughput is one instruction per cycle when issue_ready=1.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0]; both reset to 0 and wrap modulo 2^32.
  - perf_fetched increments on each enqueue.
  - perf_stall increments each RUN cycle where isend_in=0, redirect_valid=0 and enqueue is blocked by a full queue.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, memory words 0..5 = distinct opcodes, word 6 = end opcode, issue_ready=1:
  - issues pc 0..5 in order, one per cycle.
  - pc_out stops at 6.
  - halted=1 one cycle after the last issue; word 6 is never issued.
- issue_ready=0 for 10 cycles, DEPTH=4:
  - count saturates at 4 and pc_out holds at 4.
  - Raising issue_ready issues pc 0,1,2,3,4… with no gap or duplicate; perf_stall=6 with the macro defined.
- Full queue plus simultaneous deq: with count=4 and issue_ready=1 for one cycle, count stays 4 and pc_out advances by 1.
- redirect_valid=1, redirect_pc=0x20 while 3 entries are queued:
  - next cycle issue_valid=0 and pc_out=0x20.
  - next issued pc is 0x20.
- redirect_valid asserted in the same cycle isend_in=1: state stays RUN and fetch resumes at redirect_pc. After halt, a redirect is ignored: halted stays 1 and pc_out is unchanged.
- Wrap and reset:
  - PC_RESET=32'hFFFFFFFE fetches 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
  - rst asserted mid-DRAIN clears the queue; halted=0 and pc_out=PC_RESET the next cycle.
